// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf: sequential instruction prefetch from a 1-cycle ROM into a small FIFO.
// Define IF_PREFETCH_BYPASS_EN to forward a ROM word straight to fetch when the FIFO is empty.
module if_prefetch_buf #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    rom_req_o,
    output logic [31:0]             rom_addr_o,
    input  logic [31:0]             rom_inst_i,
    input  logic                    flush_i,
    input  logic [31:0]             flush_addr_i,
    output logic                    inst_valid_o,
    input  logic                    inst_ready_i,
    output logic [31:0]             inst_o,
    output logic [31:0]             inst_addr_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    logic [31:0]   pc_q, pc_d, rsp_addr_q;
    logic          rsp_valid_q;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW+1:0] credit;
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          fifo_nempty, byp, push, fifo_pop;

    // Buffered entries plus the word still in flight must never exceed DEPTH.
    assign credit      = {1'b0, cnt_q} + (AW+2)'(rsp_valid_q);
    assign fifo_nempty = cnt_q != '0;
    assign rom_req_o   = rst_n & ~flush_i & (credit < (AW+2)'(DEPTH));
    assign rom_addr_o  = pc_q;
    assign count_o     = cnt_q;
`ifdef IF_PREFETCH_BYPASS_EN
    assign byp = ~fifo_nempty & rsp_valid_q;
`else
    assign byp = 1'b0;
`endif
    assign inst_valid_o = rst_n & ~flush_i & (fifo_nempty | byp);
    assign inst_o       = ~inst_valid_o ? '0 : fifo_nempty ? inst_mem[rd_q] : rom_inst_i;
    assign inst_addr_o  = ~inst_valid_o ? '0 : fifo_nempty ? addr_mem[rd_q] : rsp_addr_q;
    assign fifo_pop     = inst_valid_o & inst_ready_i & fifo_nempty;
    // A bypassed word taken by fetch is consumed and never enters the FIFO.
    assign push         = rst_n & rsp_valid_q & ~flush_i & ~(byp & inst_ready_i);

    always_comb begin
        pc_d  = rom_req_o ? pc_q + 32'd4 : pc_q;
        rd_d  = fifo_pop ? rd_q + AW'(1) : rd_q;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            pc_q        <= flush_i ? (flush_addr_i & ~32'd3) : pc_d;
            rd_q        <= flush_i ? '0 : rd_d;
            wr_q        <= flush_i ? '0 : wr_d;
            cnt_q       <= flush_i ? '0 : cnt_d;
            rsp_valid_q <= rom_req_o;
            rsp_addr_q  <= rom_addr_o;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_q] <= rsp_addr_q;
            inst_mem[wr_q] <= rom_inst_i;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !fifo_pop && cnt_q == (AW+1)'(DEPTH)));
endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb_if_prefetch_buf: randomized scoreboard bench; the ROM returns its own address as data.
module tb_if_prefetch_buf;
    localparam int DEPTH = 4;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0, inst_ready_i = 1'b0;
    logic [31:0] flush_addr_i = '0, rom_inst_i;
    logic        rom_req_o, inst_valid_o;
    logic [31:0] rom_addr_o, inst_o, inst_addr_o;
    logic [2:0]  count_o;
    int          n_cmp = 0, n_err = 0, n_pop = 0;
    logic [31:0] exp_q[$];
    logic [31:0] gen_addr;

    if_prefetch_buf #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
        .rom_inst_i(rom_inst_i), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .count_o(count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_inst_i <= rom_req_o ? rom_addr_o : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery is simply the word-aligned sequence from the last redirect.
    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_addr);
            gen_addr = gen_addr + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        gen_addr = a & ~32'd3;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_bound", 32'(count_o <= 3'(DEPTH)), 32'd1);
            if (inst_valid_o) chk("data_eq_addr", inst_o, inst_addr_o);
            if (inst_valid_o && inst_ready_i) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL order: got %h expected nothing", inst_addr_o);
                end else chk("order", inst_addr_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n_req;
        restart(32'h0);
        // 1: reset values, then streaming with ready held high
        inst_ready_i = 1'b1;
        tick();
        #3;
        chk("rst_req", 32'(rom_req_o), 32'd0);
        chk("rst_addr", rom_addr_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_iaddr", inst_addr_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'd0);
        tick();
        rst_n = 1'b1;
        restart(32'h0);
        #3;
        chk("c0_req", 32'(rom_req_o), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) #3;
            chk("t1_valid", 32'(inst_valid_o), 32'(c >= LAT));
            tick();
        end
        // 2: ready low from reset fills exactly DEPTH entries
        rst_n = 1'b0;
        inst_ready_i = 1'b0;
        tick();
        rst_n = 1'b1;
        restart(32'h0);
        n_req = 0;
        for (int c = 0; c < 10; c++) begin
            #3;
            n_req += int'(rom_req_o);
            tick();
        end
        #3;
        chk("t2_reqs", 32'(n_req), 32'd4);
        chk("t2_count", 32'(count_o), 32'd4);
        chk("t2_req_off", 32'(rom_req_o), 32'd0);
        chk("t2_inst", inst_o, 32'h0);
        chk("t2_iaddr", inst_addr_o, 32'h0);
        tick();
        inst_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #3;
            chk("t2_nogap", 32'(inst_valid_o), 32'd1);
            tick();
        end
        // 3: flush with 3 buffered and 1 in flight
        rst_n = 1'b0;
        inst_ready_i = 1'b0;
        tick();
        rst_n = 1'b1;
        restart(32'h0);
        for (int c = 0; c < 4; c++) tick();
        #3;
        chk("t3_count", 32'(count_o), 32'd3);
        tick();
        flush_i = 1'b1;
        flush_addr_i = 32'h100;
        inst_ready_i = 1'b1;
        restart(32'h100);
        #3;
        chk("t3_flush_valid", 32'(inst_valid_o), 32'd0);
        chk("t3_flush_req", 32'(rom_req_o), 32'd0);
        tick();
        flush_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #3;
            chk("t3_refill_valid", 32'(inst_valid_o), 32'(k >= LAT + 1));
            tick();
        end
        for (int c = 0; c < 6; c++) tick();
        // 4: unaligned redirect near the top of the address space wraps to 0
        flush_i = 1'b1;
        flush_addr_i = 32'hFFFF_FFF9;
        restart(32'hFFFF_FFF9);
        tick();
        flush_i = 1'b0;
        #3;
        chk("t4_addr", rom_addr_o, 32'hFFFF_FFF8);
        for (int c = 0; c < 10; c++) tick();
        // 5: reset mid-stream with 2 entries buffered
        inst_ready_i = 1'b0;
        flush_i = 1'b1;
        flush_addr_i = 32'h200;
        restart(32'h200);
        tick();
        flush_i = 1'b0;
        for (int c = 0; c < 20 && count_o != 3'd2; c++) tick();
        chk("t5_count2", 32'(count_o), 32'd2);
        rst_n = 1'b0;
        inst_ready_i = 1'b1;
        restart(32'h0);
        #3;
        chk("t5_rst_valid", 32'(inst_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        #3;
        chk("t5_count0", 32'(count_o), 32'd0);
        chk("t5_valid0", 32'(inst_valid_o), 32'd0);
        chk("t5_addr", rom_addr_o, 32'h0);
        chk("t5_req", 32'(rom_req_o), 32'd1);
        for (int c = 0; c < 8; c++) tick();
        // 6: random ready and flush
        n_pop = 0;
        for (int c = 0; c < 2000; c++) begin
            inst_ready_i = $urandom_range(0, 3) != 0;
            flush_i = $urandom_range(0, 39) == 0;
            if (flush_i) begin
                flush_addr_i = $urandom;
                restart(flush_addr_i);
            end
            tick();
        end
        flush_i = 1'b0;
        chk("t6_progress", 32'(n_pop > 1000), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
